conv3x3_stream: RTL and testbench
=================================

// Module: conv3x3_stream
// PURPOSE
// - Parametrised 3x3 streaming convolution engine for the camera pixel path; sits after grey conversion, before VGA output.
// - Two internal line buffers, selectable kernel (bypass / Sobel-H / Sobel-V / programmable), per-frame latched config.
// - Output: absolute value, shifted and saturated; one output per accepted input, fixed latency.
// PARAMETERS
// - DW     12    pixel width, unsigned
// - CW      8    coefficient width, signed two's complement
// - IMG_W 1280   pixels per line (line buffer depth)
// - IMG_H  960   lines per frame (row counter saturation limit)
// - LAT      4   output latency in cycles; fixed, not user-tunable
// PORTS
// - iCLK        in   1      clock
// - iRST        in   1      asynchronous, active-low reset
// - iDVAL       in   1      input pixel valid; pixel accepted when high
// - iSOF        in   1      start of frame; qualified by iDVAL, marks pixel (0,0)
// - iDATA       in   DW     input pixel (grey)
// - iMODE       in   2      0 bypass, 1 Sobel-H, 2 Sobel-V, 3 programmable
// - iSHIFT      in   4      right shift applied after abs
// - iCOEF_WE    in   1      coefficient shadow write strobe
// - iCOEF_ADDR  in   4      0..8 = tl,tc,tr,ml,mc,mr,bl,bc,br; 9..15 ignored
// - iCOEF_DATA  in   CW     coefficient value
// - oDVAL       out  1      output valid; iDVAL delayed by LAT
// - oDATA       out  DW     filtered pixel
// - oBUSY       out  1      high from SOF until the last pixel of that frame leaves the pipeline
// BEHAVIOUR
// - Reset: oDVAL=0, oDATA=0, oBUSY=0; col/row counters=0; active/shadow coefs=0; active mode=0, shift=0; pipeline valids=0.
//   - Line-buffer RAM is not cleared; its contents are masked (see Border).
// - Counters advance only on iDVAL.
//   - iSOF&iDVAL: pixel is (0,0); next col=1, row=0.
//   - col wraps IMG_W-1 -> 0 and increments row; row saturates at IMG_H-1.
// - Window:
//   - Top row = line buffer 2 (oldest), middle = line buffer 1, bottom = current input.
//   - Each row has a 3-deep column shift; shifts only on iDVAL.
// - Config latch: on iSOF&iDVAL, shadow coefs, iMODE and iSHIFT copy to active regs, used for the whole frame.
//   - Coef write in the same cycle as SOF lands in shadow after the copy, so it applies to the next frame.
// - Kernels (active mode):
//   - Sobel-H = [1 2 1; 0 0 0; -1 -2 -1]
//   - Sobel-V = [1 0 -1; 2 0 -2; 1 0 -1]
//   - Programmable = active coef regs
//   - Bypass = centre pixel of the window
// - Pipeline:
//   - S1: window register
//   - S2: 9 products, signed DW+CW+1 bits
//   - S3: sum, signed DW+CW+5 bits
//   - S4: abs, then >> shift, then saturate to 2^DW-1, then border mask
//   - Data stages capture on iDVAL-delayed valid; oDVAL = iDVAL delayed exactly LAT cycles, gaps preserved.
// - Border: oDATA=0 when the input pixel producing the window has row<2 or col<2 (window incomplete).
//   - Bypass mode is masked identically.
// - oBUSY: set on SOF accept; clears when the pixel at (IMG_H-1, IMG_W-1) exits S4.
// - Reset mid-frame: everything returns to reset values immediately; the next frame requires iSOF.
// - Pixels before the first iSOF are processed with reset config (bypass).
// STRUCTURE
// - Package conv_pkg: mode enum (MODE_BYPASS/SOBEL_H/SOBEL_V/PROG), SOBEL_H/SOBEL_V coefficient constant arrays, COEF_IDX_* constants.
// - Sub-module line_buffer_2tap:
//   - Ports clken/shiftin; taps0x/taps1x; depth IMG_W, width DW.
//   - Read-before-write RAM with wrapping address counter.
// - Top holds counters, config regs, window, and the 4-stage datapath.
// TESTING (IMG_W=8, IMG_H=6, DW=12, CW=8)
// - Bypass: frame of value (row*8+col) -> oDATA = centre pixel (row-1)*8+(col-1) for row,col>=2, else 0; oDVAL exactly 4 cycles after each iDVAL.
// - Sobel-H step: rows 0-2 = 0, rows 3-5 = 100 -> outputs 400 on input rows 3 and 4 (col>=2), 0 elsewhere.
// - Programmable: write tl..br = 1, iSHIFT=3, frame all 80; check 0 in the current frame, 90 from the next SOF (720>>3), rows/cols>=2.
// - Saturation: programmable, all coefs 127, shift 0, pixels 4095 -> 4095; negative sum, e.g. all coefs -1, pixels 10 -> 90.
// - Gapped iDVAL: random 50% valid gaps, Sobel-V on a vertical step -> same values as gapless run, oDVAL pattern = iDVAL delayed 4.
// - Reset mid-frame: assert iRST at row 3 -> oDVAL/oDATA/oBUSY = 0 next edge, mode back to bypass; new SOF frame matches golden.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared definitions for the 3x3 streaming convolution engine.
// These are the kernel modes, the fixed Sobel kernels and the coefficient slot indices.
package conv_pkg;

    typedef enum logic [1:0] {
        MODE_BYPASS  = 2'd0,
        MODE_SOBEL_H = 2'd1,
        MODE_SOBEL_V = 2'd2,
        MODE_PROG    = 2'd3
    } mode_e;

    localparam int COEF_N      = 9;
    localparam int COEF_IDX_TL = 0;
    localparam int COEF_IDX_TC = 1;
    localparam int COEF_IDX_TR = 2;
    localparam int COEF_IDX_ML = 3;
    localparam int COEF_IDX_MC = 4;
    localparam int COEF_IDX_MR = 5;
    localparam int COEF_IDX_BL = 6;
    localparam int COEF_IDX_BC = 7;
    localparam int COEF_IDX_BR = 8;

    // Coefficients run row-major from top-left; the top row is the oldest line.
    localparam int SOBEL_H [COEF_N] = '{ 1,  2,  1,  0,  0,  0, -1, -2, -1};
    localparam int SOBEL_V [COEF_N] = '{ 1,  0, -1,  2,  0, -2,  1,  0, -1};

endpackage

// File: rtl/line_buffer_2tap.sv
// Two cascaded line delays sharing one wrapping address counter.
// taps0x is the pixel one line back and taps1x is the pixel two lines back; both are read before the write.
module line_buffer_2tap #(
    parameter int DW    = 12,
    parameter int IMG_W = 1280
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic          clken,
    input  logic [DW-1:0] shiftin,
    output logic [DW-1:0] taps0x,
    output logic [DW-1:0] taps1x
);

    localparam int AW = $clog2(IMG_W);

    logic [DW-1:0] r_ram0 [IMG_W];
    logic [DW-1:0] r_ram1 [IMG_W];
    logic [AW-1:0] r_addr;

    assign taps0x = r_ram0[r_addr];
    assign taps1x = r_ram1[r_addr];

    always_ff @(posedge iCLK) begin
        if (clken) begin
            r_ram0[r_addr] <= shiftin;
            r_ram1[r_addr] <= taps0x;
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_addr <= '0;
        end else if (clken) begin
            r_addr <= (r_addr == AW'(IMG_W - 1)) ? '0 : r_addr + 1'b1;
        end
    end

endmodule

// File: rtl/conv3x3_stream.sv
// 3x3 streaming convolution: position counters, per-frame config latch, window, and a 4-stage datapath.
// Every accepted pixel yields one output exactly LAT cycles later; border windows are forced to zero.
module conv3x3_stream
    import conv_pkg::*;
#(
    parameter int DW    = 12,
    parameter int CW    = 8,
    parameter int IMG_W = 1280,
    parameter int IMG_H = 960,
    parameter int LAT   = 4
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic          iDVAL,
    input  logic          iSOF,
    input  logic [DW-1:0] iDATA,
    input  logic [1:0]    iMODE,
    input  logic [3:0]    iSHIFT,
    input  logic          iCOEF_WE,
    input  logic [3:0]    iCOEF_ADDR,
    input  logic [CW-1:0] iCOEF_DATA,
    output logic          oDVAL,
    output logic [DW-1:0] oDATA,
    output logic          oBUSY
);

    localparam int PW  = DW + CW + 1;
    localparam int SW  = DW + CW + 5;
    localparam int CLW = $clog2(IMG_W);
    localparam int RWW = $clog2(IMG_H);

    function automatic logic signed [PW-1:0] f_mul(input logic [DW-1:0] pix,
                                                   input logic signed [CW-1:0] k);
        logic signed [PW-1:0] a;
        logic signed [PW-1:0] b;
        a = PW'($signed({1'b0, pix}));
        b = PW'(k);
        return a * b;
    endfunction

    function automatic logic [DW-1:0] f_abs_shift_sat(input logic signed [SW-1:0] s,
                                                      input logic [3:0] sh);
        logic [SW-1:0] mag;
        mag = s[SW-1] ? SW'(-s) : SW'(s);
        mag = mag >> sh;
        if (mag > SW'({DW{1'b1}})) return {DW{1'b1}};
        return mag[DW-1:0];
    endfunction

    logic                 w_sof;
    logic [CLW-1:0]       w_col;
    logic [RWW-1:0]       w_row;
    logic [CLW-1:0]       r_col;
    logic [RWW-1:0]       r_row;
    logic                 w_bdr;
    logic                 w_last;
    logic [DW-1:0]        w_tap0;
    logic [DW-1:0]        w_tap1;
    mode_e                r_mode;
    mode_e                w_mode;
    logic [3:0]           r_shift;
    logic [3:0]           w_shift;
    logic signed [CW-1:0] r_coef   [COEF_N];
    logic signed [CW-1:0] r_shadow [COEF_N];
    logic signed [CW-1:0] w_kern   [COEF_N];
    logic                 r_busy;

    logic                 r_vld_p1, r_vld_p2, r_vld_p3, r_vld_p4;
    logic [LAT:0]         w_vld;
    logic [DW-1:0]        r_win_p1  [COEF_N];
    logic signed [CW-1:0] r_kern_p1 [COEF_N];
    logic [3:0]           r_shift_p1, r_shift_p2, r_shift_p3;
    logic                 r_bdr_p1, r_bdr_p2, r_bdr_p3;
    logic                 r_last_p1, r_last_p2, r_last_p3, r_last_p4;
    logic signed [PW-1:0] r_prod_p2 [COEF_N];
    logic signed [SW-1:0] w_sum;
    logic signed [SW-1:0] r_sum_p3;
    logic [DW-1:0]        r_data_p4;

    assign w_vld  = {r_vld_p4, r_vld_p3, r_vld_p2, r_vld_p1, iDVAL};
    assign w_sof  = iDVAL & iSOF;
    assign w_col  = w_sof ? '0 : r_col;
    assign w_row  = w_sof ? '0 : r_row;
    assign w_bdr  = (w_row < RWW'(2)) || (w_col < CLW'(2));
    assign w_last = (w_col == CLW'(IMG_W - 1)) && (w_row == RWW'(IMG_H - 1));

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_col <= '0;
            r_row <= '0;
        end else if (iDVAL) begin
            if (w_col == CLW'(IMG_W - 1)) begin
                r_col <= '0;
                r_row <= (w_row == RWW'(IMG_H - 1)) ? w_row : w_row + 1'b1;
            end else begin
                r_col <= w_col + 1'b1;
                r_row <= w_row;
            end
        end
    end

    // A coefficient write in the SOF cycle lands in the shadow only after the copy to active.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_mode  <= MODE_BYPASS;
            r_shift <= '0;
            for (int i = 0; i < COEF_N; i++) begin
                r_coef[i]   <= '0;
                r_shadow[i] <= '0;
            end
        end else begin
            if (w_sof) begin
                r_mode  <= mode_e'(iMODE);
                r_shift <= iSHIFT;
            end
            for (int i = 0; i < COEF_N; i++) begin
                if (w_sof) r_coef[i] <= r_shadow[i];
                if (iCOEF_WE && (iCOEF_ADDR == 4'(i))) r_shadow[i] <= iCOEF_DATA;
            end
        end
    end

    // The SOF pixel itself must already see the new frame's configuration.
    always_comb begin
        w_mode  = w_sof ? mode_e'(iMODE) : r_mode;
        w_shift = w_sof ? iSHIFT : r_shift;
        for (int i = 0; i < COEF_N; i++) begin
            w_kern[i] = '0;
            case (w_mode)
                MODE_BYPASS:  w_kern[i] = (i == COEF_IDX_MC) ? CW'(1) : '0;
                MODE_SOBEL_H: w_kern[i] = CW'(SOBEL_H[i]);
                MODE_SOBEL_V: w_kern[i] = CW'(SOBEL_V[i]);
                MODE_PROG:    w_kern[i] = w_sof ? r_shadow[i] : r_coef[i];
                default:      w_kern[i] = '0;
            endcase
        end
    end

    line_buffer_2tap #(
        .DW    (DW),
        .IMG_W (IMG_W)
    ) u_lbuf (
        .iCLK    (iCLK),
        .iRST    (iRST),
        .clken   (iDVAL),
        .shiftin (iDATA),
        .taps0x  (w_tap0),
        .taps1x  (w_tap1)
    );

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_vld_p1  <= 1'b0;
            r_vld_p2  <= 1'b0;
            r_vld_p3  <= 1'b0;
            r_vld_p4  <= 1'b0;
            r_data_p4 <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_vld_p1 <= w_vld[0];
            r_vld_p2 <= w_vld[1];
            r_vld_p3 <= w_vld[2];
            r_vld_p4 <= w_vld[3];
            if (w_vld[3]) r_data_p4 <= r_bdr_p3 ? '0 : f_abs_shift_sat(r_sum_p3, r_shift_p3);
            if (w_sof) r_busy <= 1'b1;
            else if (r_vld_p4 && r_last_p4) r_busy <= 1'b0;
        end
    end

    // S1: window shift registers, top row oldest, plus per-pixel kernel and border tags
    always_ff @(posedge iCLK) begin
        if (w_vld[0]) begin
            r_win_p1[0] <= r_win_p1[1];
            r_win_p1[1] <= r_win_p1[2];
            r_win_p1[2] <= w_tap1;
            r_win_p1[3] <= r_win_p1[4];
            r_win_p1[4] <= r_win_p1[5];
            r_win_p1[5] <= w_tap0;
            r_win_p1[6] <= r_win_p1[7];
            r_win_p1[7] <= r_win_p1[8];
            r_win_p1[8] <= iDATA;
            for (int i = 0; i < COEF_N; i++) r_kern_p1[i] <= w_kern[i];
            r_shift_p1 <= w_shift;
            r_bdr_p1   <= w_bdr;
            r_last_p1  <= w_last;
        end
        // S2: nine signed products
        if (w_vld[1]) begin
            for (int i = 0; i < COEF_N; i++) r_prod_p2[i] <= f_mul(r_win_p1[i], r_kern_p1[i]);
            r_shift_p2 <= r_shift_p1;
            r_bdr_p2   <= r_bdr_p1;
            r_last_p2  <= r_last_p1;
        end
        // S3: signed sum
        if (w_vld[2]) begin
            r_sum_p3   <= w_sum;
            r_shift_p3 <= r_shift_p2;
            r_bdr_p3   <= r_bdr_p2;
            r_last_p3  <= r_last_p2;
        end
        // S4: magnitude, shift, saturate and mask happen into r_data_p4 above
        if (w_vld[3]) r_last_p4 <= r_last_p3;
    end

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < COEF_N; i++) w_sum = w_sum + SW'(r_prod_p2[i]);
    end

    assign oDVAL = w_vld[LAT];
    assign oDATA = r_data_p4;
    assign oBUSY = r_busy;

endmodule

// File: tb/tb_conv3x3_stream.sv
// Randomised self-checking bench for conv3x3_stream on an 8x6 image.
// Expected pixels come from a direct 2-D convolution of the driven frame with the config latched at SOF.
module tb_conv3x3_stream;

    localparam int DW = 12;
    localparam int CW = 8;
    localparam int W  = 8;
    localparam int H  = 6;

    logic          iCLK = 1'b0;
    logic          iRST = 1'b0;
    logic          iDVAL = 1'b0;
    logic          iSOF = 1'b0;
    logic [DW-1:0] iDATA = '0;
    logic [1:0]    iMODE = '0;
    logic [3:0]    iSHIFT = '0;
    logic          iCOEF_WE = 1'b0;
    logic [3:0]    iCOEF_ADDR = '0;
    logic [CW-1:0] iCOEF_DATA = '0;
    logic          oDVAL;
    logic [DW-1:0] oDATA;
    logic          oBUSY;

    conv3x3_stream #(.DW(DW), .CW(CW), .IMG_W(W), .IMG_H(H), .LAT(4)) dut (
        .iCLK(iCLK), .iRST(iRST), .iDVAL(iDVAL), .iSOF(iSOF), .iDATA(iDATA),
        .iMODE(iMODE), .iSHIFT(iSHIFT), .iCOEF_WE(iCOEF_WE), .iCOEF_ADDR(iCOEF_ADDR),
        .iCOEF_DATA(iCOEF_DATA), .oDVAL(oDVAL), .oDATA(oDATA), .oBUSY(oBUSY)
    );

    always #5 iCLK = ~iCLK;

    int   n_chk = 0;
    int   n_err = 0;
    int   img [H][W];
    int   sh_coef [9];
    int   act_coef [9];
    int   act_mode = 0;
    int   act_shift = 0;
    int   exp_q [$];
    logic [3:0] dv_dly;
    bit   mon_en = 1'b0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int kern(input int mode, input int idx);
        int kh [9];
        int kv [9];
        kh = '{1, 2, 1, 0, 0, 0, -1, -2, -1};
        kv = '{1, 0, -1, 2, 0, -2, 1, 0, -1};
        case (mode)
            0:       return (idx == 4) ? 1 : 0;
            1:       return kh[idx];
            2:       return kv[idx];
            default: return act_coef[idx];
        endcase
    endfunction

    function automatic int expect_px(input int r, input int c);
        int s;
        int a;
        if (r < 2 || c < 2) return 0;
        s = 0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                s += kern(act_mode, i * 3 + j) * img[r - 2 + i][c - 2 + j];
        a = (s < 0) ? -s : s;
        a = a >>> act_shift;
        return (a > 4095) ? 4095 : a;
    endfunction

    always @(posedge iCLK or negedge iRST) begin
        if (!iRST) dv_dly <= '0;
        else       dv_dly <= {dv_dly[2:0], iDVAL};
    end

    always @(negedge iCLK) begin
        if (mon_en) begin
            chk("odval_delay4", int'(oDVAL), int'(dv_dly[3]));
            if (oDVAL) begin
                if (exp_q.size() == 0) chk("odata_extra_output", exp_q.size(), 1);
                else chk("odata", int'(oDATA), exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic write_coef(input int addr, input int val);
        iCOEF_WE   = 1'b1;
        iCOEF_ADDR = 4'(addr);
        iCOEF_DATA = 8'(val);
        if (addr < 9) sh_coef[addr] = val;
        tick();
        iCOEF_WE = 1'b0;
    endtask

    task automatic put_pixel(input int r, input int c, input bit sof, input int mode, input int shift);
        iDVAL  = 1'b1;
        iSOF   = sof;
        iDATA  = 12'(img[r][c]);
        iMODE  = 2'(mode);
        iSHIFT = 4'(shift);
        if (sof) begin
            act_mode  = mode;
            act_shift = shift;
            act_coef  = sh_coef;
        end
        exp_q.push_back(expect_px(r, c));
        tick();
        iDVAL = 1'b0;
        iSOF  = 1'b0;
        if (sof) chk("obusy_after_sof", int'(oBUSY), 1);
    endtask

    task automatic run_rows(input int mode, input int shift, input bit sof, input bit gaps,
                            input int r0, input int r1);
        for (int r = r0; r < r1; r++)
            for (int c = 0; c < W; c++) begin
                while (gaps && $urandom_range(0, 1) == 0) tick();
                put_pixel(r, c, sof && r == 0 && c == 0, mode, shift);
            end
    endtask

    task automatic drain();
        repeat (8) tick();
        chk("drain_queue_empty", exp_q.size(), 0);
        chk("obusy_after_drain", int'(oBUSY), 0);
    endtask

    task automatic fill_random();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) img[r][c] = int'($urandom_range(0, 4095));
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 9; i++) begin
            sh_coef[i]  = 0;
            act_coef[i] = 0;
        end
        repeat (3) tick();
        chk("rst_odval", int'(oDVAL), 0);
        chk("rst_odata", int'(oDATA), 0);
        chk("rst_obusy", int'(oBUSY), 0);
        iRST = 1'b1;
        tick();
        mon_en = 1'b1;

        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = r * 8 + c;
        run_rows(0, 0, 1, 0, 0, H);
        drain();

        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = (r < 3) ? 0 : 100;
        run_rows(1, 0, 1, 0, 0, H);
        drain();

        // coefficients written mid-frame only take effect at the next SOF
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = 80;
        run_rows(3, 3, 1, 0, 0, 3);
        for (int a = 0; a < 9; a++) write_coef(a, 1);
        write_coef(12, 55);
        run_rows(3, 3, 1, 0, 3, H);
        drain();
        run_rows(3, 3, 1, 0, 0, H);
        drain();

        for (int a = 0; a < 9; a++) write_coef(a, 127);
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = 4095;
        run_rows(3, 0, 1, 0, 0, H);
        drain();
        for (int a = 0; a < 9; a++) write_coef(a, -1);
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = 10;
        run_rows(3, 0, 1, 0, 0, H);
        drain();

        for (int a = 0; a < 9; a++) write_coef(a, int'($urandom_range(0, 255)) - 128);
        fill_random();
        run_rows(3, int'($urandom_range(0, 6)), 1, 1, 0, H);
        drain();

        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = (c < 4) ? 0 : 200;
        run_rows(2, 0, 1, 0, 0, H);
        drain();
        run_rows(2, 0, 1, 1, 0, H);
        drain();
        fill_random();
        run_rows(1, 1, 1, 1, 0, H);
        drain();

        fill_random();
        run_rows(2, 0, 1, 0, 0, 4);
        mon_en = 1'b0;
        iRST = 1'b0;
        #1;
        chk("midrst_odval", int'(oDVAL), 0);
        chk("midrst_odata", int'(oDATA), 0);
        chk("midrst_obusy", int'(oBUSY), 0);
        tick();
        chk("midrst_odval_edge", int'(oDVAL), 0);
        chk("midrst_obusy_edge", int'(oBUSY), 0);
        exp_q.delete();
        act_mode  = 0;
        act_shift = 0;
        for (int i = 0; i < 9; i++) begin
            act_coef[i] = 0;
            sh_coef[i]  = 0;
        end
        iRST = 1'b1;
        tick();
        mon_en = 1'b1;

        // without SOF the reset configuration (bypass) stays in force
        fill_random();
        run_rows(1, 5, 0, 0, 0, H);
        drain();
        fill_random();
        run_rows(2, 0, 1, 0, 0, H);
        drain();

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
